// File: rtl/riscv_pkg.sv
// Shared core constants: register width, index width,
// zero-register index and default register-file port counts.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  localparam int RF_NUM_RD = 2;
  localparam int RF_NUM_WR = 1;

endpackage

// File: rtl/rf_write_sel.sv
// Matches one register index against all write ports.
// Highest-index enabled port wins; the zero register never hits.
module rf_write_sel
  import riscv_pkg::*;
#(
  parameter int DATA_W   = XLEN,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int NUM_WR   = RF_NUM_WR,
  parameter int ZERO_REG = 1
) (
  input  logic [ADDR_W-1:0]        addr,
  input  logic [NUM_WR-1:0]        w_enb,
  input  logic [NUM_WR*ADDR_W-1:0] w_addr,
  input  logic [NUM_WR*DATA_W-1:0] w_data,
  output logic                     hit,
  output logic [DATA_W-1:0]        data
);

  always_comb begin
    hit  = 1'b0;
    data = '0;
    // later ports override earlier ones
    for (int p = 0; p < NUM_WR; p++) begin
      if (w_enb[p] &&
          w_addr[p*ADDR_W +: ADDR_W] == addr) begin
        hit  = 1'b1;
        data = w_data[p*DATA_W +: DATA_W];
      end
    end
    if (ZERO_REG != 0 &&
        addr == ADDR_W'(REG_ZERO)) begin
      hit  = 1'b0;
      data = '0;
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port integer register file with zero register,
// write-port priority, optional bypass and registered read.
module register_file_mp
  import riscv_pkg::*;
#(
  parameter int DATA_W   = XLEN,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int NUM_RD   = RF_NUM_RD,
  parameter int NUM_WR   = RF_NUM_WR,
  parameter int BYPASS   = 1,
  parameter int REG_READ = 0,
  parameter int ZERO_REG = 1
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst_n,
  input  logic                     i_Enb,
  input  logic [NUM_WR-1:0]        iv_W_Enb,
  input  logic [NUM_WR*ADDR_W-1:0] iv_Write_R,
  input  logic [NUM_WR*DATA_W-1:0] iv_Write_Data,
  input  logic [NUM_RD*ADDR_W-1:0] iv_Read_R,
  output logic [NUM_RD*DATA_W-1:0] ov_Data
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem    [DEPTH];
  logic [DEPTH-1:0]  e_hit;
  logic [DATA_W-1:0] e_data [DEPTH];

  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    rf_write_sel #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_WR   (NUM_WR),
      .ZERO_REG (ZERO_REG)
    ) u_sel (
      .addr   (ADDR_W'(e)),
      .w_enb  (iv_W_Enb),
      .w_addr (iv_Write_R),
      .w_data (iv_Write_Data),
      .hit    (e_hit[e]),
      .data   (e_data[e])
    );

    always_ff @(posedge i_Clk) begin
      if (!i_Rst_n)
        mem[e] <= '0;
      else if (i_Enb && e_hit[e])
        mem[e] <= e_data[e];
    end
  end

  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              r_hit;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] stored;
    logic [DATA_W-1:0] fresh;

    assign ra = iv_Read_R[r*ADDR_W +: ADDR_W];

    rf_write_sel #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_WR   (NUM_WR),
      .ZERO_REG (ZERO_REG)
    ) u_byp (
      .addr   (ra),
      .w_enb  (iv_W_Enb),
      .w_addr (iv_Write_R),
      .w_data (iv_Write_Data),
      .hit    (r_hit),
      .data   (r_data)
    );

    assign stored =
      (ZERO_REG != 0 && ra == ADDR_W'(REG_ZERO))
      ? '0 : mem[ra];

    // value the entry holds once this edge's writes land
    assign fresh = r_hit ? r_data : stored;

    if (REG_READ != 0) begin : g_reg
      logic [DATA_W-1:0] q;

      always_ff @(posedge i_Clk) begin
        if (!i_Rst_n)
          q <= '0;
        else if (i_Enb)
          q <= fresh;
      end

      assign ov_Data[r*DATA_W +: DATA_W] = q;
    end else begin : g_comb
      assign ov_Data[r*DATA_W +: DATA_W] =
        (BYPASS != 0 && i_Rst_n && i_Enb)
        ? fresh : stored;
    end
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Randomised and directed checks of three register_file_mp
// configurations against an array model of the register file.
module tb_register_file_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enb;
  logic [1:0]  wen;
  logic [9:0]  wa;
  logic [63:0] wd;
  logic [9:0]  ra;
  logic [63:0] data_a;
  logic [63:0] data_b;
  logic [63:0] data_c;

  int compared = 0;
  int failed   = 0;
  bit ready    = 1'b0;

  logic [31:0] mdl [32];
  logic [31:0] mq  [2];

  always #5 clk = ~clk;

  register_file_mp #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2),
    .BYPASS(1), .REG_READ(0), .ZERO_REG(1)
  ) u_a (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Enb(enb),
    .iv_W_Enb(wen), .iv_Write_R(wa),
    .iv_Write_Data(wd), .iv_Read_R(ra),
    .ov_Data(data_a)
  );

  register_file_mp #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2),
    .BYPASS(0), .REG_READ(0), .ZERO_REG(1)
  ) u_b (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Enb(enb),
    .iv_W_Enb(wen), .iv_Write_R(wa),
    .iv_Write_Data(wd), .iv_Read_R(ra),
    .ov_Data(data_b)
  );

  register_file_mp #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2),
    .BYPASS(1), .REG_READ(1), .ZERO_REG(1)
  ) u_c (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Enb(enb),
    .iv_W_Enb(wen), .iv_Write_R(wa),
    .iv_Write_Data(wd), .iv_Read_R(ra),
    .ov_Data(data_c)
  );

  // register contents as seen after the current writes retire
  function automatic logic [31:0] after_val(
    input logic [4:0] a
  );
    logic [31:0] v;
    v = mdl[a];
    for (int p = 0; p < 2; p++)
      if (wen[p] && wa[p*5 +: 5] == a && a != 5'd0)
        v = wd[p*32 +: 32];
    return v;
  endfunction

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      ready = 1'b1;
      for (int i = 0; i < 32; i++) mdl[i] = '0;
      mq[0] = '0;
      mq[1] = '0;
    end else if (enb) begin
      logic [31:0] nxt [32];
      for (int r = 0; r < 2; r++)
        mq[r] = after_val(ra[r*5 +: 5]);
      for (int i = 0; i < 32; i++)
        nxt[i] = after_val(5'(i));
      for (int i = 0; i < 32; i++) mdl[i] = nxt[i];
    end
  end

  always @(negedge clk) begin
    if (ready) begin
      for (int r = 0; r < 2; r++) begin
        logic [4:0]  a;
        logic [31:0] ea;
        a  = ra[r*5 +: 5];
        ea = (rst_n && enb) ? after_val(a) : mdl[a];
        chk($sformatf("byp_p%0d", r),
            data_a[r*32 +: 32], ea);
        chk($sformatf("nobyp_p%0d", r),
            data_b[r*32 +: 32], mdl[a]);
        chk($sformatf("regrd_p%0d", r),
            data_c[r*32 +: 32], mq[r]);
      end
    end
  end

  task automatic set_in(
    input logic        r,
    input logic        e,
    input logic [1:0]  we,
    input logic [4:0]  a0,
    input logic [31:0] d0,
    input logic [4:0]  a1,
    input logic [31:0] d1,
    input logic [4:0]  r0,
    input logic [4:0]  r1
  );
    rst_n = r;
    enb   = e;
    wen   = we;
    wa    = {a1, a0};
    wd    = {d1, d0};
    ra    = {r1, r0};
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    set_in(0, 1, 2'b00, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();

    for (int a = 0; a < 32; a++) begin
      set_in(1, 1, 2'b00, 0, 0, 0, 0, 5'(a), 0);
      @(negedge clk);
      chk("rst_zero", data_a[31:0], 32'h0);
      tick();
    end

    set_in(1, 1, 2'b01, 0, 32'hDEADBEEF, 0, 0, 0, 0);
    @(negedge clk);
    chk("r0_byp", data_a[31:0], 32'h0);
    tick();
    set_in(1, 1, 2'b00, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("r0_wr", data_a[31:0], 32'h0);
    tick();

    set_in(1, 1, 2'b01, 10, 123456789, 0, 0, 10, 11);
    @(negedge clk);
    chk("r10_byp", data_a[31:0], 123456789);
    chk("r10_nobyp", data_b[31:0], 32'h0);
    tick();
    set_in(1, 1, 2'b00, 0, 0, 0, 0, 10, 11);
    @(negedge clk);
    chk("r10_rd", data_a[31:0], 123456789);
    chk("r11_rd", data_a[63:32], 32'h0);
    chk("r10_reg", data_c[31:0], 123456789);
    for (int a = 0; a <= 10; a++) begin
      set_in(1, 1, 2'b00, 0, 0, 0, 0, 5'(a), 5'(a));
      @(negedge clk);
      chk("step_p0", data_b[31:0],
          (a == 10) ? 32'd123456789 : 32'd0);
      chk("step_p1", data_b[63:32],
          (a == 10) ? 32'd123456789 : 32'd0);
      tick();
    end

    set_in(1, 1, 2'b01, 5, 32'hAA, 0, 0, 5, 0);
    @(negedge clk);
    chk("byp_same", data_a[31:0], 32'hAA);
    chk("nobyp_pre", data_b[31:0], 32'h0);
    tick();
    set_in(1, 1, 2'b00, 0, 0, 0, 0, 5, 0);
    @(negedge clk);
    chk("nobyp_post", data_b[31:0], 32'hAA);
    tick();

    set_in(1, 1, 2'b11, 7, 32'h1111, 7, 32'h2222, 7, 7);
    @(negedge clk);
    chk("conf_byp", data_a[31:0], 32'h2222);
    tick();
    set_in(1, 1, 2'b00, 0, 0, 0, 0, 7, 7);
    @(negedge clk);
    chk("conf_wr", data_b[31:0], 32'h2222);
    tick();

    set_in(1, 1, 2'b11, 7, 32'h33, 0, 32'h44, 7, 0);
    @(negedge clk);
    chk("zero_byp", data_a[63:32], 32'h0);
    tick();
    set_in(1, 1, 2'b00, 0, 0, 0, 0, 7, 0);
    @(negedge clk);
    chk("r7_33", data_b[31:0], 32'h33);
    chk("r0_still0", data_b[63:32], 32'h0);
    tick();

    set_in(1, 1, 2'b01, 3, 32'h55, 0, 0, 3, 0);
    tick();
    set_in(1, 1, 2'b00, 0, 0, 0, 0, 3, 0);
    @(negedge clk);
    chk("reg_wf", data_c[31:0], 32'h55);
    set_in(1, 0, 2'b01, 4, 32'h77, 0, 0, 4, 0);
    @(negedge clk);
    chk("reg_hold_pre", data_c[31:0], 32'h55);
    tick();
    @(negedge clk);
    chk("reg_hold", data_c[31:0], 32'h55);
    set_in(1, 1, 2'b00, 0, 0, 0, 0, 4, 0);
    @(negedge clk);
    chk("r4_nowr", data_b[31:0], 32'h0);
    tick();
    @(negedge clk);
    chk("reg_r4", data_c[31:0], 32'h0);

    for (int i = 1; i <= 4; i++) begin
      set_in(1, 1, 2'b01, 5'(i), 32'(i), 0, 0, 5'(i), 0);
      tick();
    end
    set_in(0, 1, 2'b01, 9, 32'h99, 0, 0, 9, 4);
    @(negedge clk);
    chk("rst_nobyp", data_a[31:0], 32'h0);
    tick();
    set_in(1, 1, 2'b00, 0, 0, 0, 0, 1, 9);
    @(negedge clk);
    chk("rst_q0", data_c[31:0], 32'h0);
    chk("rst_q1", data_c[63:32], 32'h0);
    for (int i = 1; i <= 5; i++) begin
      logic [4:0] a;
      a = (i == 5) ? 5'd9 : 5'(i);
      set_in(1, 1, 2'b00, 0, 0, 0, 0, a, a);
      @(negedge clk);
      chk("rst_mid", data_a[31:0], 32'h0);
      tick();
    end

    for (int n = 0; n < 3000; n++) begin
      logic [4:0] a0, a1, r0, r1;
      bit nar;
      nar = ($urandom_range(0, 1) == 1);
      a0 = nar ? 5'($urandom_range(0, 7))
               : 5'($urandom_range(0, 31));
      a1 = nar ? 5'($urandom_range(0, 7))
               : 5'($urandom_range(0, 31));
      r0 = nar ? 5'($urandom_range(0, 7))
               : 5'($urandom_range(0, 31));
      r1 = nar ? 5'($urandom_range(0, 7))
               : 5'($urandom_range(0, 31));
      set_in($urandom_range(0, 63) != 0,
             $urandom_range(0, 7) != 0,
             2'($urandom_range(0, 3)),
             a0, $urandom, a1, $urandom, r0, r1);
      tick();
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, failed);
    $finish;
  end

endmodule
